reg_bank_wr_8x8b: RTL and testbench

// - Write side of the 8x8-bit register bank; the read side is the 8-input 8-bit mux on the A..H buses.
// - Accepts write requests (select + byte) over a valid/ready handshake.
// - Decodes the 3-bit select into one of eight write strobes (74138-style) and commits the byte one cycle after acceptance.
// - Also performs a sequenced bank clear, one register per cycle, walked by a 3-bit counter (74161-style).

---
 rtl/reg_bank_wr_8x8b_pkg.sv | 27 ++
 rtl/reg_bank_wr_8x8b_if.sv | 27 ++
 rtl/reg_bank_wr_8x8b_ttl74138.sv | 17 +
 rtl/reg_bank_wr_8x8b.sv | 135 +++++++++++++
 tb/tb_reg_bank_wr_8x8b.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_wr_8x8b_pkg.sv
// Shared constants and types for the write side of the 8x8-bit register bank.
package reg_bank_wr_8x8b_pkg;

  localparam int REG_WIDTH = 8;
  localparam int NREG      = 8;
  localparam int SEL_W     = 3;

  // Index of the last register; the clear sweep ends on it.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREG - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic [SEL_W-1:0] {
    REG_A = 3'd0,
    REG_B = 3'd1,
    REG_C = 3'd2,
    REG_D = 3'd3,
    REG_E = 3'd4,
    REG_F = 3'd5,
    REG_G = 3'd6,
    REG_H = 3'd7
  } reg_idx_e;

endpackage

// File: rtl/reg_bank_wr_8x8b_if.sv
// Write-request / clear handshake and register-bank outputs.
interface reg_bank_wr_8x8b_if;
  import reg_bank_wr_8x8b_pkg::*;

  logic                 WrValid;
  logic [SEL_W-1:0]     WrSel;
  logic [REG_WIDTH-1:0] WrData;
  logic                 WrReady;
  logic                 ClrReq;
  logic                 ClrDone;
  logic                 Busy;
  logic [NREG-1:0]      Dirty;
  logic [REG_WIDTH-1:0] A, B, C, D, E, F, G, H;

  // Requester side: drives writes and clear requests, observes the bank.
  modport master (
    output WrValid, WrSel, WrData, ClrReq,
    input  WrReady, ClrDone, Busy, Dirty, A, B, C, D, E, F, G, H
  );

  // Bank side.
  modport slave (
    input  WrValid, WrSel, WrData, ClrReq,
    output WrReady, ClrDone, Busy, Dirty, A, B, C, D, E, F, G, H
  );

endinterface

// File: rtl/reg_bank_wr_8x8b_ttl74138.sv
// 3-to-8 decoder with enable, producing active-high per-register load strobes.
module ttl74138
  import reg_bank_wr_8x8b_pkg::*;
(
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [NREG-1:0]  strobe_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      assign strobe_o[gi] = en_i && (sel_i == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_bank_wr_8x8b.sv
// Write side of the 8x8-bit register bank: one-entry write stage, clear
// sequencer (IDLE/CLEAR with a 3-bit sweep counter), eight registers and Dirty.
module reg_bank_wr_8x8b
  import reg_bank_wr_8x8b_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  reg_bank_wr_8x8b_if.slave   bus
);

  logic                 stage_valid_q;
  logic [SEL_W-1:0]     stage_sel_q;
  logic [REG_WIDTH-1:0] stage_data_q;
  logic                 clr_pending_q;
  state_e               state_q;
  logic [SEL_W-1:0]     count_q;
  logic                 clr_done_q;

  logic                 wr_ready;
  logic                 accept;
  logic                 busy;
  logic                 clearing;
  logic                 dec_en;
  logic [SEL_W-1:0]     dec_sel;
  logic [NREG-1:0]      strobe;
  logic [REG_WIDTH-1:0] reg_q [NREG];
  logic [NREG-1:0]      dirty_vec;

  assign clearing = (state_q == CLEAR);
  assign wr_ready = (state_q == IDLE) && !clr_pending_q;
  assign accept   = bus.WrValid && wr_ready;
  assign busy     = clr_pending_q || clearing;

  // The decoder is shared: staged writes address it in IDLE, the sweep counter in CLEAR.
  assign dec_en  = clearing ? 1'b1    : stage_valid_q;
  assign dec_sel = clearing ? count_q : stage_sel_q;

  ttl74138 u_dec (
    .en_i     (dec_en),
    .sel_i    (dec_sel),
    .strobe_o (strobe)
  );

  // Capture an accepted request; the stage drains every cycle so it never blocks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stage_valid_q <= 1'b0;
      stage_sel_q   <= '0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_sel_q  <= bus.WrSel;
        stage_data_q <= bus.WrData;
      end
    end
  end

  // Latch a clear request until the sweep can start; requests while busy are dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_pending_q <= 1'b0;
    end else if (bus.ClrReq && !busy) begin
      clr_pending_q <= 1'b1;
    end else if ((state_q == IDLE) && clr_pending_q && !stage_valid_q) begin
      clr_pending_q <= 1'b0;
    end
  end

  // Clear sequencer: waits for the stage to drain, then sweeps registers 0..7.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (clr_pending_q && !stage_valid_q) begin
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          count_q <= count_q + 1'b1;
          if (count_q == LAST_IDX) begin
            state_q    <= IDLE;
            clr_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [REG_WIDTH-1:0] data_q;
      logic                 dirty_q;

      // Load the staged byte on a commit strobe, or zero it on a sweep strobe.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          data_q  <= '0;
          dirty_q <= 1'b0;
        end else if (strobe[gi]) begin
          data_q  <= clearing ? '0 : stage_data_q;
          dirty_q <= !clearing;
        end
      end

      assign reg_q[gi]     = data_q;
      assign dirty_vec[gi] = dirty_q;
    end
  endgenerate

  assign bus.WrReady = wr_ready;
  assign bus.Busy    = busy;
  assign bus.ClrDone = clr_done_q;
  assign bus.Dirty   = dirty_vec;
  assign bus.A       = reg_q[int'(REG_A)];
  assign bus.B       = reg_q[int'(REG_B)];
  assign bus.C       = reg_q[int'(REG_C)];
  assign bus.D       = reg_q[int'(REG_D)];
  assign bus.E       = reg_q[int'(REG_E)];
  assign bus.F       = reg_q[int'(REG_F)];
  assign bus.G       = reg_q[int'(REG_G)];
  assign bus.H       = reg_q[int'(REG_H)];

endmodule

// File: tb/tb_reg_bank_wr_8x8b.sv
// Self-checking bench for reg_bank_wr_8x8b: table-driven writes with a commit
// scoreboard, plus hand-written clear, overlap and reset sequences.
module tb_reg_bank_wr_8x8b;
  import reg_bank_wr_8x8b_pkg::*;

  logic Clk;
  logic Reset_n;

  reg_bank_wr_8x8b_if bus_if ();

  reg_bank_wr_8x8b dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    int         gap;
    logic [7:0] exp_dirty;
  } vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    int         due;
  } sb_t;

  vec_t       tbl [6];
  sb_t        sb [$];
  logic [7:0] model_regs [8];
  logic [7:0] model_dirty;
  int         edge_cnt;
  int         total;
  int         bad;

  function automatic logic [7:0] get_reg(input int idx);
    case (idx)
      0: return bus_if.A;
      1: return bus_if.B;
      2: return bus_if.C;
      3: return bus_if.D;
      4: return bus_if.E;
      5: return bus_if.F;
      6: return bus_if.G;
      default: return bus_if.H;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    model_dirty = 8'h00;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_reg%0d", tag, i), {24'h0, get_reg(i)}, {24'h0, model_regs[i]});
    check($sformatf("%s_dirty", tag), {24'h0, bus_if.Dirty}, {24'h0, model_dirty});
  endtask

  // One clock: record an accept at the rising edge, then at the falling edge
  // retire every scoreboard entry whose commit edge has passed.
  task automatic tick();
    logic acc;
    sb_t  e;
    acc = Reset_n && bus_if.WrValid && bus_if.WrReady;
    @(posedge Clk);
    edge_cnt++;
    if (acc) sb.push_back('{sel: bus_if.WrSel, data: bus_if.WrData, due: edge_cnt + 1});
    @(negedge Clk);
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      e = sb.pop_front();
      model_regs[e.sel] = e.data;
      model_dirty[e.sel] = 1'b1;
      $display("commit sel=%0d data=%02h -> reg=%02h dirty=%02h", e.sel, e.data, get_reg(int'(e.sel)), bus_if.Dirty);
      check($sformatf("commit_reg%0d", e.sel), {24'h0, get_reg(int'(e.sel))}, {24'h0, e.data});
      check("commit_dirty", {24'h0, bus_if.Dirty}, {24'h0, model_dirty});
    end
  endtask

  // Present a request and hold it until accepted (bounded wait).
  task automatic do_write(input logic [2:0] s, input logic [7:0] d);
    int waited;
    waited = 0;
    bus_if.WrValid = 1'b1;
    bus_if.WrSel   = s;
    bus_if.WrData  = d;
    while (!bus_if.WrReady && waited < 40) begin
      tick();
      waited++;
    end
    if (!bus_if.WrReady) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      tick();
    end
    bus_if.WrValid = 1'b0;
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    edge_cnt = 0;
    model_clear();
    Reset_n        = 1'b0;
    bus_if.WrValid = 1'b0;
    bus_if.WrSel   = 3'd0;
    bus_if.WrData  = 8'h00;
    bus_if.ClrReq  = 1'b0;

    tbl[0] = '{sel: 3'd3, data: 8'h5A, gap: 1, exp_dirty: 8'h08};
    tbl[1] = '{sel: 3'd0, data: 8'h11, gap: 0, exp_dirty: 8'h09};
    tbl[2] = '{sel: 3'd7, data: 8'hEE, gap: 0, exp_dirty: 8'h89};
    tbl[3] = '{sel: 3'd0, data: 8'h22, gap: 1, exp_dirty: 8'h89};
    tbl[4] = '{sel: 3'd5, data: 8'hC3, gap: 1, exp_dirty: 8'hA9};
    tbl[5] = '{sel: 3'd2, data: 8'h7F, gap: 1, exp_dirty: 8'hAD};

    // Reset state
    repeat (3) tick();
    check_all("reset");
    check("reset_busy", {31'h0, bus_if.Busy}, 32'd0);
    check("reset_clrdone", {31'h0, bus_if.ClrDone}, 32'd0);
    Reset_n = 1'b1;
    tick();
    check("ready_after_reset", {31'h0, bus_if.WrReady}, 32'd1);

    // Table-driven writes, including back-to-back ones
    for (int v = 0; v < 6; v++) begin
      check($sformatf("ready_v%0d", v), {31'h0, bus_if.WrReady}, 32'd1);
      do_write(tbl[v].sel, tbl[v].data);
      $display("write v%0d sel=%0d data=%02h", v, tbl[v].sel, tbl[v].data);
      for (int g = 0; g < tbl[v].gap; g++) tick();
      if (tbl[v].gap > 0) begin
        check($sformatf("tbl_dirty_v%0d", v), {24'h0, bus_if.Dirty}, {24'h0, tbl[v].exp_dirty});
        check_all($sformatf("tbl_v%0d", v));
      end
    end
    check("b2b_A", {24'h0, bus_if.A}, 32'h22);
    check("b2b_H", {24'h0, bus_if.H}, 32'hEE);

    // Full clear sweep from all-FF
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'hFF);
    tick();
    check_all("loaded");
    bus_if.ClrReq = 1'b1;
    tick();
    bus_if.ClrReq = 1'b0;
    check("clr_busy", {31'h0, bus_if.Busy}, 32'd1);
    check("clr_ready", {31'h0, bus_if.WrReady}, 32'd0);
    for (int j = 1; j <= 9; j++) begin
      tick();
      for (int i = 0; i < 8; i++)
        check($sformatf("sweep_j%0d_reg%0d", j, i), {24'h0, get_reg(i)},
              (i <= j - 2) ? 32'h00 : 32'hFF);
      check($sformatf("sweep_j%0d_done", j), {31'h0, bus_if.ClrDone}, (j == 9) ? 32'd1 : 32'd0);
      check($sformatf("sweep_j%0d_busy", j), {31'h0, bus_if.Busy}, (j == 9) ? 32'd0 : 32'd1);
      $display("sweep cycle %0d dirty=%02h done=%0b", j, bus_if.Dirty, bus_if.ClrDone);
    end
    tick();
    check("clrdone_pulse_end", {31'h0, bus_if.ClrDone}, 32'd0);
    model_clear();
    check_all("after_clear");

    // Accept and ClrReq in the same cycle, then a request held through the sweep
    bus_if.WrValid = 1'b1;
    bus_if.WrSel   = 3'd5;
    bus_if.WrData  = 8'hC3;
    bus_if.ClrReq  = 1'b1;
    check("simul_ready", {31'h0, bus_if.WrReady}, 32'd1);
    tick();
    bus_if.ClrReq = 1'b0;
    bus_if.WrSel  = 3'd1;
    bus_if.WrData = 8'hAB;
    n = 0;
    while (!bus_if.ClrDone && n < 30) begin
      check("held_not_ready", {31'h0, bus_if.WrReady}, 32'd0);
      tick();
      n++;
    end
    check("simul_clrdone_latency", n, 32'd10);
    model_clear();
    check_all("simul_after_clear");
    check("held_ready_at_done", {31'h0, bus_if.WrReady}, 32'd1);
    tick();
    bus_if.WrValid = 1'b0;
    tick();
    check("held_B", {24'h0, bus_if.B}, 32'hAB);

    // Reset in the middle of a sweep
    do_write(3'd4, 8'h44);
    do_write(3'd6, 8'h66);
    tick();
    bus_if.ClrReq = 1'b1;
    tick();
    bus_if.ClrReq = 1'b0;
    repeat (5) tick();
    Reset_n = 1'b0;
    #1;
    sb.delete();
    model_clear();
    check_all("midclr_reset");
    check("midclr_busy", {31'h0, bus_if.Busy}, 32'd0);
    check("midclr_done", {31'h0, bus_if.ClrDone}, 32'd0);
    check("midclr_ready", {31'h0, bus_if.WrReady}, 32'd1);
    tick();
    Reset_n = 1'b1;
    tick();
    do_write(3'd2, 8'h7F);
    tick();
    check_all("post_reset_write");
    check("post_reset_C", {24'h0, bus_if.C}, 32'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
